push_to_axis_mux: RTL

//  Multi-channel successor of the single-channel push-to-AXIS converter.

---
 rtl/push_to_axis_mux_if.sv | 37 +++
 rtl/push_to_axis_mux.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/push_to_axis_mux_if.sv
// Bundle of the push-side and stream-side signals of push_to_axis_mux.
// Parameters mirror the widths of the block that uses it.
//   idata/ienable : per-channel push words and strobes (into the block)
//   iafull        : per-channel almost-full flags (out of the block)
//   overflow      : per-channel sticky drop flags (out), oclear clears them (in)
//   drop_count    : saturating dropped-word total (out), cclear clears it (in)
//   odata/ochan/ovalid/oready : AXI stream towards the sink
// The slave modport is the view of the block itself; master is the view of
// whatever drives the pushes and sinks the stream.
interface push_to_axis_mux_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int ID_WIDTH   = 2,
  parameter int CNT_WIDTH  = 16
);
  logic [CHANNELS*DATA_WIDTH-1:0] idata;
  logic [CHANNELS-1:0]            ienable;
  logic [CHANNELS-1:0]            iafull;
  logic [CHANNELS-1:0]            overflow;
  logic [CHANNELS-1:0]            oclear;
  logic [CNT_WIDTH-1:0]           drop_count;
  logic                           cclear;
  logic [DATA_WIDTH-1:0]          odata;
  logic [ID_WIDTH-1:0]            ochan;
  logic                           ovalid;
  logic                           oready;

  modport master (
    output idata, ienable, oclear, cclear, oready,
    input  iafull, overflow, drop_count, odata, ochan, ovalid
  );

  modport slave (
    input  idata, ienable, oclear, cclear, oready,
    output iafull, overflow, drop_count, odata, ochan, ovalid
  );
endinterface

// File: rtl/push_to_axis_mux.sv
// push_to_axis_mux: merges CHANNELS clock-enable push inputs into one registered
// AXI stream tagged with the source channel id.
//   clock  : single rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : slave view of push_to_axis_mux_if (pushes, flags, counter, stream)
// Each channel owns a FIFO of 2**ADDR_WIDTH-1 words. A word pushed into a full
// FIFO is dropped (never overwrites queued data), sets that channel's sticky
// overflow flag and bumps a shared saturating drop counter. A round-robin
// arbiter refills the output register whenever it is empty or being taken.
// Pushes pass through an input register first, so a word sampled at edge k
// enters its FIFO at edge k+1 and can be presented on the stream after k+2.
module push_to_axis_mux #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int CHANNELS    = 4,
  parameter int ID_WIDTH    = 2,
  parameter int AFULL_LIMIT = 1 << (ADDR_WIDTH - 1),
  parameter int CNT_WIDTH   = 16
) (
  input  logic               clock,
  input  logic               resetn,
  push_to_axis_mux_if.slave  bus
);
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  // Wide enough to hold the counter plus one cycle's worth of drops.
  localparam int SUM_WIDTH = CNT_WIDTH + $clog2(CHANNELS + 1);
  localparam logic [ADDR_WIDTH-1:0] FULL_LEVEL = {ADDR_WIDTH{1'b1}};
  localparam logic [SUM_WIDTH-1:0]  CNT_MAX    =
    {{(SUM_WIDTH-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

  // Registered push inputs
  logic [CHANNELS*DATA_WIDTH-1:0] in_data_q, in_data_d;
  logic [CHANNELS-1:0]            in_push_q, in_push_d;

  // FIFO state
  logic [CHANNELS-1:0][ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [CHANNELS-1:0][ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0]               mem_q [CHANNELS][DEPTH];

  // Flags, counter, output register, arbiter pointer
  logic [CHANNELS-1:0]   iafull_q, iafull_d;
  logic [CHANNELS-1:0]   overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic [ID_WIDTH-1:0]   ochan_q, ochan_d;
  logic                  ovalid_q, ovalid_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

  // Combinational helpers
  logic [CHANNELS-1:0][ADDR_WIDTH-1:0] size_s;
  logic [CHANNELS-1:0]   accept_s;
  logic [CHANNELS-1:0]   drop_s;
  logic [CHANNELS-1:0]   pop_s;
  logic                  load_s;
  logic                  grant_valid_s;
  logic [ID_WIDTH-1:0]   grant_id_s;
  logic [ID_WIDTH-1:0]   cand_s;
  logic                  take_s;
  logic [DATA_WIDTH-1:0] grant_data_s;
  logic [SUM_WIDTH-1:0]  drop_sum_s;
  logic [SUM_WIDTH-1:0]  next_count_s;

  // Input capture stage
  always_comb begin
    in_data_d = bus.idata;
    in_push_d = bus.ienable;
  end

  // FIFO occupancy, wrapping difference of the pointers
  always_comb begin
    size_s = {(CHANNELS*ADDR_WIDTH){1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      size_s[c] = waddr_q[c] - raddr_q[c];
    end
  end

  // Round-robin arbiter: first non-empty channel after the last granted one
  always_comb begin
    load_s        = !ovalid_q || bus.oready;
    grant_valid_s = 1'b0;
    grant_id_s    = ptr_q;
    cand_s        = ptr_q;
    take_s        = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand_s        = ID_WIDTH'((int'(ptr_q) + i) % CHANNELS);
      take_s        = !grant_valid_s && (size_s[cand_s] != {ADDR_WIDTH{1'b0}});
      grant_id_s    = take_s ? cand_s : grant_id_s;
      grant_valid_s = grant_valid_s || take_s;
    end
    grant_data_s = mem_q[grant_id_s][raddr_q[grant_id_s]];
    pop_s = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      pop_s[c] = load_s && grant_valid_s && (grant_id_s == ID_WIDTH'(c));
    end
  end

  // Accept/drop decision and FIFO pointer updates; a pop frees a full FIFO
  always_comb begin
    accept_s = {CHANNELS{1'b0}};
    drop_s   = {CHANNELS{1'b0}};
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    iafull_d = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      accept_s[c] = in_push_q[c] && ((size_s[c] != FULL_LEVEL) || pop_s[c]);
      drop_s[c]   = in_push_q[c] && !accept_s[c];
      waddr_d[c]  = waddr_q[c] + {{(ADDR_WIDTH-1){1'b0}}, accept_s[c]};
      raddr_d[c]  = raddr_q[c] + {{(ADDR_WIDTH-1){1'b0}}, pop_s[c]};
      iafull_d[c] = int'(size_s[c]) >= AFULL_LIMIT;
    end
  end

  // Sticky overflow (a new drop beats oclear) and saturating drop counter
  always_comb begin
    overflow_d = drop_s | (overflow_q & ~bus.oclear);
    drop_sum_s = {SUM_WIDTH{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      drop_sum_s = drop_sum_s + {{(SUM_WIDTH-1){1'b0}}, drop_s[c]};
    end
    next_count_s = {{(SUM_WIDTH-CNT_WIDTH){1'b0}}, drop_count_q} + drop_sum_s;
    if (bus.cclear) begin
      drop_count_d = {CNT_WIDTH{1'b0}};
    end else if (next_count_s > CNT_MAX) begin
      drop_count_d = {CNT_WIDTH{1'b1}};
    end else begin
      drop_count_d = next_count_s[CNT_WIDTH-1:0];
    end
  end

  // Output register: refill on load, otherwise hold for the sink
  always_comb begin
    odata_d  = odata_q;
    ochan_d  = ochan_q;
    ovalid_d = ovalid_q;
    ptr_d    = ptr_q;
    if (load_s) begin
      ovalid_d = grant_valid_s;
      if (grant_valid_s) begin
        odata_d = grant_data_s;
        ochan_d = grant_id_s;
        ptr_d   = grant_id_s;
      end else begin
        odata_d = odata_q;
        ochan_d = ochan_q;
        ptr_d   = ptr_q;
      end
    end else begin
      ovalid_d = ovalid_q;
    end
  end

  // FIFO storage; contents need no reset because the pointers are reset
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (accept_s[c]) begin
        mem_q[c][waddr_q[c]] <= in_data_q[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_data_q    <= {(CHANNELS*DATA_WIDTH){1'b0}};
      in_push_q    <= {CHANNELS{1'b0}};
      waddr_q      <= {(CHANNELS*ADDR_WIDTH){1'b0}};
      raddr_q      <= {(CHANNELS*ADDR_WIDTH){1'b0}};
      iafull_q     <= {CHANNELS{1'b1}};
      overflow_q   <= {CHANNELS{1'b0}};
      drop_count_q <= {CNT_WIDTH{1'b0}};
      odata_q      <= {DATA_WIDTH{1'b0}};
      ochan_q      <= {ID_WIDTH{1'b0}};
      ovalid_q     <= 1'b0;
      ptr_q        <= {ID_WIDTH{1'b0}};
    end else begin
      in_data_q    <= in_data_d;
      in_push_q    <= in_push_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      iafull_q     <= iafull_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      odata_q      <= odata_d;
      ochan_q      <= ochan_d;
      ovalid_q     <= ovalid_d;
      ptr_q        <= ptr_d;
    end
  end

  assign bus.iafull     = iafull_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;
  assign bus.odata      = odata_q;
  assign bus.ochan      = ochan_q;
  assign bus.ovalid     = ovalid_q;
endmodule
